// File: rtl/llc_op_scheduler.sv
// LLC front-end sequencer: merges processor and snoop request FIFOs into one
// registered op stream, with snoop priority, a starvation guard and maintenance sequencing.

module llc_op_sched_fifo #(
   parameter int DW    = 36,
   parameter int DEPTH = 4
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [DW-1:0] i_data,
   input  logic          i_pop,
   output logic [DW-1:0] o_data,
   output logic          o_empty,
   output logic          o_full
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW:0]   r_wp, r_rp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (i_push) r_wp <= r_wp + {{AW{1'b0}}, 1'b1};
         if (i_pop)  r_rp <= r_rp + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wp[AW-1:0]] <= i_data;
   end

   assign o_data  = r_mem[r_rp[AW-1:0]];
   assign o_empty = (r_wp == r_rp);
   // Extra pointer bit distinguishes full from empty when the indices match.
   assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
endmodule

module llc_op_scheduler #(
   parameter int ADDR_W     = 32,
   parameter int PQ_DEPTH   = 4,
   parameter int SQ_DEPTH   = 4,
   parameter int STARVE_MAX = 3,
   parameter int IDLE_OP    = 9
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              p_valid,
   output logic              p_ready,
   input  logic [3:0]        p_op,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [3:0]        s_op,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic              ctl_valid,
   output logic              ctl_ready,
   input  logic [3:0]        ctl_op,
   output logic [31:0]       llc_op,
   output logic [ADDR_W-1:0] llc_addr,
   output logic              llc_issue,
   output logic              err_illegal,
   output logic [15:0]       p_issued,
   output logic [15:0]       s_issued
);
   localparam int DW = ADDR_W + 4;
   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_CTL} state_t;

   state_t            r_state, w_state_nxt;
   logic              r_rdy_en;
   logic              r_ctl_pend;
   logic [3:0]        r_ctl_op;
   logic [SW-1:0]     r_starve;
   logic [31:0]       r_llc_op;
   logic [ADDR_W-1:0] r_llc_addr;
   logic              r_llc_issue;
   logic              r_err;
   logic [15:0]       r_p_cnt, r_s_cnt;

   logic          w_p_acc, w_s_acc, w_c_acc;
   logic          w_p_legal, w_s_legal, w_c_legal;
   logic          w_pq_empty, w_pq_full, w_sq_empty, w_sq_full;
   logic [DW-1:0] w_pq_head, w_sq_head;
   logic          w_arb, w_sel_s, w_sel_p;

   assign w_p_legal = (p_op <= 4'd2);
   assign w_s_legal = (s_op >= 4'd3) && (s_op <= 4'd6);
   assign w_c_legal = (ctl_op == 4'd8) || (ctl_op == 4'd9);

   // Readiness is gated off until the first clock after reset release.
   assign p_ready   = r_rdy_en && (r_state == ST_RUN) && !w_pq_full;
   assign s_ready   = r_rdy_en && (r_state == ST_RUN) && !w_sq_full;
   assign ctl_ready = r_rdy_en && (r_state == ST_RUN) && !r_ctl_pend;

   assign w_p_acc = p_valid && p_ready;
   assign w_s_acc = s_valid && s_ready;
   assign w_c_acc = ctl_valid && ctl_ready;

   assign w_arb   = (r_state != ST_CTL);
   assign w_sel_s = w_arb && !w_sq_empty && ((r_starve < STARVE_LIM) || w_pq_empty);
   assign w_sel_p = w_arb && !w_sel_s && !w_pq_empty;

   llc_op_sched_fifo #(.DW(DW), .DEPTH(PQ_DEPTH)) u_pq (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_p_acc && w_p_legal),
      .i_data  ({p_op, p_addr}),
      .i_pop   (w_sel_p),
      .o_data  (w_pq_head),
      .o_empty (w_pq_empty),
      .o_full  (w_pq_full)
   );

   llc_op_sched_fifo #(.DW(DW), .DEPTH(SQ_DEPTH)) u_sq (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_s_acc && w_s_legal),
      .i_data  ({s_op, s_addr}),
      .i_pop   (w_sel_s),
      .o_data  (w_sq_head),
      .o_empty (w_sq_empty),
      .o_full  (w_sq_full)
   );

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_RUN:   if (w_c_acc && w_c_legal) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (w_pq_empty && w_sq_empty) w_state_nxt = ST_CTL;
         ST_CTL:   w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_RUN;
         r_rdy_en   <= 1'b0;
         r_ctl_pend <= 1'b0;
         r_ctl_op   <= 4'd0;
         r_starve   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_rdy_en <= 1'b1;
         if (w_c_acc && w_c_legal) begin
            r_ctl_pend <= 1'b1;
            r_ctl_op   <= ctl_op;
         end else if (r_state == ST_CTL) begin
            r_ctl_pend <= 1'b0;
         end
         // Consecutive snoop wins only count while the processor side is waiting.
         if (w_sel_s)      r_starve <= w_pq_empty ? '0 : r_starve + {{(SW-1){1'b0}}, 1'b1};
         else if (w_sel_p) r_starve <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_llc_op    <= 32'(IDLE_OP);
         r_llc_addr  <= '0;
         r_llc_issue <= 1'b0;
         r_err       <= 1'b0;
         r_p_cnt     <= 16'd0;
         r_s_cnt     <= 16'd0;
      end else begin
         r_err <= (w_p_acc && !w_p_legal) || (w_s_acc && !w_s_legal) ||
                  (w_c_acc && !w_c_legal);
         if (r_state == ST_CTL) begin
            r_llc_op    <= {28'd0, r_ctl_op};
            r_llc_addr  <= '0;
            r_llc_issue <= 1'b1;
         end else if (w_sel_s) begin
            r_llc_op    <= {28'd0, w_sq_head[DW-1:ADDR_W]};
            r_llc_addr  <= w_sq_head[ADDR_W-1:0];
            r_llc_issue <= 1'b1;
            r_s_cnt     <= r_s_cnt + 16'd1;
         end else if (w_sel_p) begin
            r_llc_op    <= {28'd0, w_pq_head[DW-1:ADDR_W]};
            r_llc_addr  <= w_pq_head[ADDR_W-1:0];
            r_llc_issue <= 1'b1;
            r_p_cnt     <= r_p_cnt + 16'd1;
         end else begin
            r_llc_op    <= 32'(IDLE_OP);
            r_llc_issue <= 1'b0;
         end
      end
   end

   assign llc_op      = r_llc_op;
   assign llc_addr    = r_llc_addr;
   assign llc_issue   = r_llc_issue;
   assign err_illegal = r_err;
   assign p_issued    = r_p_cnt;
   assign s_issued    = r_s_cnt;
endmodule

// File: tb/tb_llc_op_scheduler.sv
// Scoreboard bench for llc_op_scheduler: a queue-based reference model predicts each
// cycle's output; a monitor process compares what the DUT presents after every edge.

module tb_llc_op_scheduler;
   localparam int PQD = 4;
   localparam int SQD = 4;
   localparam int STV = 3;
   localparam int IDL = 9;

   logic        clk = 1'b0;
   logic        reset;
   logic        p_valid = 1'b0, s_valid = 1'b0, ctl_valid = 1'b0;
   logic        p_ready, s_ready, ctl_ready;
   logic [3:0]  p_op = '0, s_op = '0, ctl_op = '0;
   logic [31:0] p_addr = '0, s_addr = '0;
   logic [31:0] llc_op, llc_addr;
   logic        llc_issue, err_illegal;
   logic [15:0] p_issued, s_issued;

   llc_op_scheduler dut (
      .clk(clk), .reset(reset),
      .p_valid(p_valid), .p_ready(p_ready), .p_op(p_op), .p_addr(p_addr),
      .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_addr(s_addr),
      .ctl_valid(ctl_valid), .ctl_ready(ctl_ready), .ctl_op(ctl_op),
      .llc_op(llc_op), .llc_addr(llc_addr), .llc_issue(llc_issue),
      .err_illegal(err_illegal), .p_issued(p_issued), .s_issued(s_issued)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] op;
      logic [31:0] addr;
      logic        issue;
      logic        err;
      logic [15:0] pc;
      logic [15:0] sc;
   } exp_t;

   exp_t        sb[$];
   logic [35:0] mpq[$], msq[$];
   int          m_mode;   // 0 run, 1 draining, 2 maintenance issue
   int          m_starve;
   logic [15:0] m_pc, m_sc;
   bit          m_pend, m_rdy;
   logic [3:0]  m_cop;
   logic [31:0] m_addr;
   int          n_vec = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_starve = 0; m_pc = '0; m_sc = '0;
      m_pend = 0; m_rdy = 0; m_cop = '0; m_addr = '0;
      mpq.delete(); msq.delete(); sb.delete();
   endtask

   task automatic chk_reset_vals();
      chk("rst llc_op", llc_op, 32'(IDL));
      chk("rst llc_addr", llc_addr, 32'd0);
      chk("rst llc_issue", 32'(llc_issue), 32'd0);
      chk("rst err", 32'(err_illegal), 32'd0);
      chk("rst p_issued", 32'(p_issued), 32'd0);
      chk("rst s_issued", 32'(s_issued), 32'd0);
      chk("rst p_ready", 32'(p_ready), 32'd0);
      chk("rst s_ready", 32'(s_ready), 32'd0);
      chk("rst ctl_ready", 32'(ctl_ready), 32'd0);
   endtask

   // Drive one cycle of inputs, check readiness, and predict what the next edge produces.
   task automatic apply(input bit pv, input logic [3:0] pop, input logic [31:0] pa,
                        input bit sv, input logic [3:0] sop, input logic [31:0] sa,
                        input bit cv, input logic [3:0] cop);
      bit pr, sr, cr, pacc, sacc, cacc, pl, sl, cl, pe, se;
      exp_t e;
      logic [35:0] h;
      p_valid = pv; p_op = pop; p_addr = pa;
      s_valid = sv; s_op = sop; s_addr = sa;
      ctl_valid = cv; ctl_op = cop;
      pr = m_rdy && m_mode == 0 && mpq.size() < PQD;
      sr = m_rdy && m_mode == 0 && msq.size() < SQD;
      cr = m_rdy && m_mode == 0 && !m_pend;
      chk("p_ready", 32'(p_ready), 32'(pr));
      chk("s_ready", 32'(s_ready), 32'(sr));
      chk("ctl_ready", 32'(ctl_ready), 32'(cr));
      pacc = pv && pr; sacc = sv && sr; cacc = cv && cr;
      pl = pop <= 2; sl = sop >= 3 && sop <= 6; cl = cop == 8 || cop == 9;
      e.err   = (pacc && !pl) || (sacc && !sl) || (cacc && !cl);
      e.op    = 32'(IDL);
      e.addr  = m_addr;
      e.issue = 1'b0;
      pe = mpq.size() == 0;
      se = msq.size() == 0;
      if (m_mode == 2) begin
         e.op = 32'(m_cop); e.addr = '0; e.issue = 1'b1;
         m_mode = 0; m_pend = 0;
      end else begin
         if (!se && (m_starve < STV || pe)) begin
            h = msq.pop_front();
            e.op = 32'(h[35:32]); e.addr = h[31:0]; e.issue = 1'b1;
            m_sc++;
            m_starve = pe ? 0 : m_starve + 1;
         end else if (!pe) begin
            h = mpq.pop_front();
            e.op = 32'(h[35:32]); e.addr = h[31:0]; e.issue = 1'b1;
            m_pc++;
            m_starve = 0;
         end
         if (m_mode == 1 && pe && se) m_mode = 2;
      end
      m_addr = e.addr;
      if (pacc && pl) mpq.push_back({pop, pa});
      if (sacc && sl) msq.push_back({sop, sa});
      if (cacc && cl) begin m_mode = 1; m_pend = 1; m_cop = cop; end
      e.pc = m_pc; e.sc = m_sc;
      m_rdy = 1;
      sb.push_back(e);
   endtask

   task automatic drive(input bit pv, input logic [3:0] pop, input logic [31:0] pa,
                        input bit sv, input logic [3:0] sop, input logic [31:0] sa,
                        input bit cv, input logic [3:0] cop);
      @(negedge clk);
      apply(pv, pop, pa, sv, sop, sa, cv, cop);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 4'd0, 32'd0, 0, 4'd3, 32'd0, 0, 4'd9);
   endtask

   task automatic rnd(input int n, input int ppct, input int spct, input int cpct, input int ipct);
      bit pv, sv, cv;
      logic [3:0] pop, sop, cop;
      int v;
      for (int i = 0; i < n; i++) begin
         pv = int'($urandom_range(0, 99)) < ppct;
         sv = int'($urandom_range(0, 99)) < spct;
         cv = int'($urandom_range(0, 99)) < cpct;
         if (int'($urandom_range(0, 99)) < ipct) pop = 4'($urandom_range(3, 15));
         else pop = 4'($urandom_range(0, 2));
         if (int'($urandom_range(0, 99)) < ipct) begin
            v = int'($urandom_range(0, 11));
            sop = 4'(v < 3 ? v : v + 4);
         end else sop = 4'($urandom_range(3, 6));
         if (int'($urandom_range(0, 99)) < ipct) begin
            v = int'($urandom_range(0, 13));
            cop = 4'(v < 8 ? v : v + 2);
         end else cop = 4'($urandom_range(8, 9));
         drive(pv, pop, $urandom, sv, sop, $urandom, cv, cop);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      p_valid = 0; s_valid = 0; ctl_valid = 0;
      #1;
      chk_reset_vals();
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      apply(0, 4'd0, 32'd0, 0, 4'd3, 32'd0, 0, 4'd9);
   endtask

   // Monitor: the DUT presents a registered output every clock.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("llc_op", llc_op, e.op);
            chk("llc_addr", llc_addr, e.addr);
            chk("llc_issue", 32'(llc_issue), 32'(e.issue));
            chk("err_illegal", 32'(err_illegal), 32'(e.err));
            chk("p_issued", 32'(p_issued), 32'(e.pc));
            chk("s_issued", 32'(s_issued), 32'(e.sc));
         end
      end
   end

   initial begin
      model_reset();
      reset = 1'b1;
      #2 reset = 1'b0;
      #1 chk_reset_vals();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      apply(0, 4'd0, 32'd0, 0, 4'd3, 32'd0, 0, 4'd9);
      idle(2);
      // single processor op
      drive(1, 4'd0, 32'h1000, 0, 4'd3, 32'd0, 0, 4'd9);
      idle(3);
      // starvation guard: two processor entries under continuous snoop traffic
      drive(1, 4'd1, 32'h2000, 1, 4'd3, 32'h3000, 0, 4'd9);
      drive(1, 4'd2, 32'h2004, 1, 4'd3, 32'h3004, 0, 4'd9);
      for (int i = 0; i < 10; i++) drive(0, 4'd0, 32'd0, 1, 4'd3, 32'h3100 + 32'(i), 0, 4'd9);
      idle(6);
      // processor FIFO fills while snoops dominate
      for (int i = 0; i < 16; i++)
         drive(1, 4'd1, 32'h4000 + 32'(i), 1, 4'd4, 32'h5000 + 32'(i), 0, 4'd9);
      idle(12);
      // maintenance clear after two queued processor ops
      drive(1, 4'd0, 32'h6000, 0, 4'd3, 32'd0, 0, 4'd9);
      drive(1, 4'd2, 32'h6004, 0, 4'd3, 32'd0, 1, 4'd8);
      for (int i = 0; i < 6; i++) drive(1, 4'd0, 32'h6100, 1, 4'd5, 32'h6200, 0, 4'd9);
      idle(4);
      // maintenance with empty FIFOs, then illegal ops from all sources together
      drive(0, 4'd0, 32'd0, 0, 4'd3, 32'd0, 1, 4'd9);
      idle(4);
      drive(0, 4'd0, 32'd0, 1, 4'd1, 32'h7000, 0, 4'd9);
      idle(2);
      drive(1, 4'd7, 32'h7100, 1, 4'd9, 32'h7200, 1, 4'd3);
      idle(2);
      rnd(400, 40, 40, 5, 10);
      rnd(200, 80, 80, 2, 5);
      // reset with work queued
      rnd(6, 100, 100, 0, 0);
      do_reset();
      idle(2);
      rnd(300, 50, 50, 4, 10);
      idle(10);
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/llc_op_scheduler.md
Name: llc_op_scheduler

Overview:
- Front-end sequencer for the LLC. It merges processor-side requests (ops 0-2) and bus-snoop requests (ops 3-6) into the single op/addr stream the LLC consumes every clock.
- It also sequences maintenance commands: clear (op 8) and print (op 9).
- It buffers each source in a small FIFO, arbitrates with snoop priority plus a starvation guard, and drives a harmless idle op when nothing is issued.

Parameters:
ADDR_W, 32, address width
PQ_DEPTH, 4, processor FIFO depth (power of 2, >=2)
SQ_DEPTH, 4, snoop FIFO depth (power of 2, >=2)
STARVE_MAX, 3, max consecutive snoop grants while processor FIFO is non-empty
IDLE_OP, 9, op driven to LLC when idle (print; no state or counter change)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
p_valid  in  1  processor request valid
p_ready  out  1  processor request accepted when p_valid&&p_ready
p_op  in  4  processor op, legal 0,1,2
p_addr  in  ADDR_W  processor address
s_valid  in  1  snoop request valid
s_ready  out  1  snoop accept
s_op  in  4  snoop op, legal 3,4,5,6
s_addr  in  ADDR_W  snoop address
ctl_valid  in  1  maintenance command valid
ctl_ready  out  1  maintenance accept
ctl_op  in  4  legal 8 (clear) or 9 (print)
llc_op  out  32  op to LLC (integer encoding)
llc_addr  out  ADDR_W  address to LLC
llc_issue  out  1  1 when llc_op is a real issued op
err_illegal  out  1  one-cycle pulse on dropped illegal op
p_issued  out  16  count of processor ops issued, wraps
s_issued  out  16  count of snoop ops issued, wraps

Behaviour:
- Reset values (async, while reset==0): llc_op=IDLE_OP, llc_addr=0, llc_issue=0, err_illegal=0, counters=0, FIFOs empty, starve count=0, FSM=RUN, ready outputs=0. Ready outputs are 1 from the first clock after deassertion.
- Reset mid-operation discards all queued requests and any pending maintenance command.
- FSM states:
  - RUN: normal arbitration.
  - DRAIN: maintenance command accepted; no new p/s accepted; FIFOs emptied by normal arbitration.
  - CTL: issue the maintenance op for exactly one cycle, then return to RUN.
- Handshakes:
  - p_ready = RUN && !pq_full; s_ready = RUN && !sq_full.
  - ctl_ready = RUN && !ctl_valid_latched. A ctl command is accepted only in RUN.
  - No bypass: a push into a full FIFO is never accepted, even if that FIFO pops in the same cycle.
- Illegal ops (p_op outside 0-2, s_op outside 3-6, ctl_op outside 8/9):
  - Handshake completes; op is not enqueued.
  - err_illegal=1 the next cycle. Simultaneous illegal ops from several sources still give a single pulse.
- Latency: a request accepted at edge N is earliest on llc_op/llc_addr after edge N+1. Outputs are registered; one op issued per cycle.
- Arbitration each cycle in RUN/DRAIN:
  - Snoop FIFO non-empty and (starve<STARVE_MAX or processor FIFO empty): issue snoop head; starve increments if processor FIFO non-empty, else clears.
  - Otherwise processor FIFO non-empty: issue processor head; starve=0.
  - Neither: llc_op=IDLE_OP, llc_issue=0, llc_addr holds its previous value.
- DRAIN->CTL when both FIFOs are empty at the edge (a ctl accepted with empty FIFOs goes to DRAIN then CTL next cycle).
- CTL: llc_op=ctl_op, llc_addr=0, llc_issue=1 for one cycle; RUN next.
- Ordering: per-source FIFO order is preserved; no cross-source reordering beyond the arbitration rule.
- Counters: p_issued/s_issued increment on each issue from their FIFO; 16-bit wrap 0xFFFF->0. Maintenance ops are not counted.

Test Plan:
- Reset released, no traffic -> llc_op=9, llc_issue=0, counters 0; p_ready=s_ready=ctl_ready=1 after first clock.
- Push p(op0,0x1000) at edge N -> llc_op=0, llc_addr=0x1000, llc_issue=1 after edge N+1; p_issued=1.
- Snoop FIFO kept non-empty with ops 3, processor FIFO holding 2 entries -> issue pattern S,S,S,P,S,S,S,P (STARVE_MAX=3).
- Fill processor FIFO with 4 entries while outputs stall under snoop traffic -> p_ready=0 at 4 entries; 5th push not accepted; no entry lost or duplicated.
- Queue 2 processor ops, then ctl_op=8 -> both ops issued, then llc_op=8 for exactly one cycle; p_ready=0 during DRAIN/CTL; RUN afterwards.
- s_op=1 pushed -> err_illegal pulse one cycle, nothing issued, s_issued unchanged; assert reset while FIFOs are non-empty -> outputs at reset values immediately, FIFOs empty after release.
